// File: rtl/cpu_ctrl_pkg.sv
// Package: cpu_ctrl_pkg
// Shared definitions for the hardwired control unit:
//   - instruction/opcode field widths
//   - opcode and ALU-operation encodings
//   - FSM state encoding (4 bit)
//   - instruction-class encoding produced by cu_decode
// Optional feature macro used by the control unit: CU_MEM_WAIT_EN.
package cpu_ctrl_pkg;

    localparam int unsigned IRW_DEF = 32;
    localparam int unsigned OPW_DEF = 5;

    // Opcodes
    localparam logic [OPW_DEF-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW_DEF-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW_DEF-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW_DEF-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW_DEF-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW_DEF-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW_DEF-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW_DEF-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPW_DEF-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPW_DEF-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPW_DEF-1:0] OP_BRX  = 5'b10010;
    localparam logic [OPW_DEF-1:0] OP_JR   = 5'b10100;
    localparam logic [OPW_DEF-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW_DEF-1:0] OP_HALT = 5'b11011;

    // ALU operations driven on alu_op (same encoding as the R-type opcodes)
    localparam logic [OPW_DEF-1:0] ALU_NONE = 5'b00000;
    localparam logic [OPW_DEF-1:0] ALU_ADD  = 5'b00011;
    localparam logic [OPW_DEF-1:0] ALU_AND  = 5'b00101;
    localparam logic [OPW_DEF-1:0] ALU_OR   = 5'b00110;

    typedef enum logic [3:0] {
        StRst  = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StT7   = 4'd8,
        StHalt = 4'd9
    } state_e;

    typedef enum logic [3:0] {
        ClsRtype = 4'd0,
        ClsImm   = 4'd1,
        ClsLdi   = 4'd2,
        ClsLd    = 4'd3,
        ClsSt    = 4'd4,
        ClsBrx   = 4'd5,
        ClsJr    = 4'd6,
        ClsNop   = 4'd7,
        ClsHalt  = 4'd8
    } instr_class_e;

    // ldi, ld and st all form base + constant in T3/T4
    function automatic logic is_base_addr(input instr_class_e cls);
        return (cls == ClsLdi) || (cls == ClsLd) || (cls == ClsSt);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Module: cu_decode
// Combinational opcode decoder for the control unit.
// Ports:
//   i_opcode  in   OPW  opcode field of the IR
//   o_class   out  4    instruction class (instr_class_e)
//   o_alu_op  out  OPW  ALU operation used by the class's ALU step
module cu_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPW_DEF-1:0] i_opcode,
    output instr_class_e       o_class,
    output logic [OPW_DEF-1:0] o_alu_op
);

    always_comb begin
        o_class  = ClsNop;
        // Address and branch-target arithmetic is an add.
        o_alu_op = ALU_ADD;
        unique case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                o_class  = ClsRtype;
                o_alu_op = i_opcode;
            end
            OP_ADDI: begin
                o_class  = ClsImm;
                o_alu_op = ALU_ADD;
            end
            OP_ANDI: begin
                o_class  = ClsImm;
                o_alu_op = ALU_AND;
            end
            OP_ORI: begin
                o_class  = ClsImm;
                o_alu_op = ALU_OR;
            end
            OP_LDI:  o_class = ClsLdi;
            OP_LD:   o_class = ClsLd;
            OP_ST:   o_class = ClsSt;
            OP_BRX:  o_class = ClsBrx;
            OP_JR:   o_class = ClsJr;
            OP_HALT: o_class = ClsHalt;
            default: o_class = ClsNop;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Module: control_unit
// Hardwired control FSM: fetches, decodes and sequences each instruction by driving the
// datapath's bus/register strobes, one control step per clock.
// Ports:
//   clk, clr (sync, active-high)             clock and reset
//   ir [IRW-1:0], con_ff                     IR contents, branch condition flip-flop
//   mem_ready                                memory handshake (CU_MEM_WAIT_EN only)
//   PCout Zlowout MDRout BAout Cout          bus drivers
//   MARin MDRin IRin Yin Zin PCin CONin      register loads
//   IncPC Read Write RAM_read RAM_write      PC/memory controls
//   GRA GRB GRC Rin Rout                     register-field select/strobe
//   alu_op [OPW-1:0]                         ALU operation
//   run                                      1 while executing (0 in RST and HALT)
// Configuration macro: CU_MEM_WAIT_EN -- adds mem_ready; T1, ld-T6 and st-T7 hold until it
// is high at the clock edge.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IRW = IRW_DEF,
    parameter int unsigned OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [IRW-1:0] ir,
    input  logic           con_ff,
`ifdef CU_MEM_WAIT_EN
    input  logic           mem_ready,
`endif
    output logic           PCout,
    output logic           Zlowout,
    output logic           MDRout,
    output logic           BAout,
    output logic           Cout,
    output logic           MARin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           Zin,
    output logic           PCin,
    output logic           CONin,
    output logic           IncPC,
    output logic           Read,
    output logic           Write,
    output logic           RAM_read,
    output logic           RAM_write,
    output logic           GRA,
    output logic           GRB,
    output logic           GRC,
    output logic           Rin,
    output logic           Rout,
    output logic [OPW-1:0] alu_op,
    output logic           run
);

    state_e             r_state;
    state_e             w_state_next;
    instr_class_e       w_class;
    logic [OPW-1:0]     w_alu_op;
    logic               w_mem_ready;
    logic               w_unused_ir;

`ifdef CU_MEM_WAIT_EN
    assign w_mem_ready = mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Only the opcode field matters to control.
    assign w_unused_ir = ^ir[IRW-OPW-1:0];

    cu_decode u_decode (
        .i_opcode (ir[IRW-1 -: OPW]),
        .o_class  (w_class),
        .o_alu_op (w_alu_op)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= StRst;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state. The T2 halt/nop decision reads ir during T2, so the fetched word must be
    // visible on ir by then.
    always_comb begin
        w_state_next = StT0;
        unique case (r_state)
            StRst:  w_state_next = StT0;
            StT0:   w_state_next = StT1;
            StT1:   w_state_next = w_mem_ready ? StT2 : StT1;
            StT2: begin
                if (w_class == ClsHalt) begin
                    w_state_next = StHalt;
                end else if (w_class == ClsNop) begin
                    w_state_next = StT0;
                end else begin
                    w_state_next = StT3;
                end
            end
            StT3:   w_state_next = (w_class == ClsJr) ? StT0 : StT4;
            StT4:   w_state_next = StT5;
            StT5: begin
                if ((w_class == ClsLd) || (w_class == ClsSt) || (w_class == ClsBrx)) begin
                    w_state_next = StT6;
                end else begin
                    w_state_next = StT0;
                end
            end
            StT6: begin
                if (w_class == ClsLd) begin
                    w_state_next = w_mem_ready ? StT7 : StT6;
                end else if (w_class == ClsSt) begin
                    w_state_next = StT7;
                end else begin
                    w_state_next = StT0;
                end
            end
            StT7: begin
                if ((w_class == ClsSt) && !w_mem_ready) begin
                    w_state_next = StT7;
                end else begin
                    w_state_next = StT0;
                end
            end
            StHalt: w_state_next = StHalt;
            default: w_state_next = StT0;
        endcase
    end

    // Moore outputs from (state, instruction class); brx-T6 also looks at con_ff.
    always_comb begin
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        BAout     = 1'b0;
        Cout      = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        CONin     = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        RAM_read  = 1'b0;
        RAM_write = 1'b0;
        GRA       = 1'b0;
        GRB       = 1'b0;
        GRC       = 1'b0;
        Rin       = 1'b0;
        Rout      = 1'b0;
        alu_op    = ALU_NONE;
        run       = (r_state != StRst) && (r_state != StHalt);

        unique case (r_state)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                Zlowout  = 1'b1;
                PCin     = 1'b1;
                Read     = 1'b1;
                RAM_read = 1'b1;
                MDRin    = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                if ((w_class == ClsRtype) || (w_class == ClsImm)) begin
                    GRB  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else if (is_base_addr(w_class)) begin
                    // BAout reads R0 as zero, giving an absolute address when rb = R0.
                    GRB   = 1'b1;
                    BAout = 1'b1;
                    Yin   = 1'b1;
                end else if (w_class == ClsBrx) begin
                    GRA   = 1'b1;
                    Rout  = 1'b1;
                    CONin = 1'b1;
                end else if (w_class == ClsJr) begin
                    GRA  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end
            end
            StT4: begin
                if (w_class == ClsRtype) begin
                    GRC    = 1'b1;
                    Rout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = w_alu_op;
                end else if ((w_class == ClsImm) || is_base_addr(w_class)) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = w_alu_op;
                end else if (w_class == ClsBrx) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
            end
            StT5: begin
                if ((w_class == ClsRtype) || (w_class == ClsImm) || (w_class == ClsLdi)) begin
                    Zlowout = 1'b1;
                    GRA     = 1'b1;
                    Rin     = 1'b1;
                end else if ((w_class == ClsLd) || (w_class == ClsSt)) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (w_class == ClsBrx) begin
                    Cout   = 1'b1;
                    Zin    = 1'b1;
                    alu_op = w_alu_op;
                end
            end
            StT6: begin
                if (w_class == ClsLd) begin
                    Read     = 1'b1;
                    RAM_read = 1'b1;
                    MDRin    = 1'b1;
                end else if (w_class == ClsSt) begin
                    GRA   = 1'b1;
                    Rout  = 1'b1;
                    MDRin = 1'b1;
                end else if ((w_class == ClsBrx) && con_ff) begin
                    Zlowout = 1'b1;
                    PCin    = 1'b1;
                end
            end
            StT7: begin
                if (w_class == ClsLd) begin
                    MDRout = 1'b1;
                    GRA    = 1'b1;
                    Rin    = 1'b1;
                end else if (w_class == ClsSt) begin
                    Write     = 1'b1;
                    RAM_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
